// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control
//
// Multi-cycle controller for a small MIPS-like datapath. A single FSM walks
// each instruction through fetch, decode, execute, memory and write-back
// states. All datapath controls are combinational decodes of the current
// state and the instruction fields. The only registered outputs are the state
// itself and the sticky illegal flag.
//
// Ports
//   clk        in   1  rising-edge clock
//   reset      in   1  synchronous, active-high reset
//   op         in   6  instruction[31:26] from the instruction register
//   funct      in   6  instruction[5:0]
//   zero       in   1  ALU zero flag, used by beq
//   mem_ready  in   1  memory handshake; access completes when high
//   pc_we      out  1  PC write enable
//   ir_we      out  1  instruction register write enable
//   mem_re     out  1  memory read request
//   mem_we     out  1  memory write request
//   reg_we     out  1  register file write enable
//   ext_op     out  1  immediate extension: 1 sign, 0 zero
//   alu_src_a  out  1  0 PC, 1 rs
//   alu_src_b  out  2  0 rt, 1 const 4, 2 ext imm, 3 ext imm << 2
//   alu_ctl    out  3  0 add, 1 sub, 2 and, 3 or, 4 slt
//   reg_dst    out  1  0 rt, 1 rd
//   mem_to_reg out  1  0 ALU result, 1 memory data
//   pc_src     out  2  0 ALU result, 1 ALUOut, 2 jump target
//   state      out  4  current FSM state (debug)
//   illegal    out  1  sticky unsupported-instruction flag
// ---------------------------------------------------------------------------
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_we,
  output logic       ext_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctl,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM4 = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  state_t cur_state;
  state_t nxt_state;

  // Raw enables before the reset gate.
  logic pc_we_raw;
  logic ir_we_raw;
  logic mem_re_raw;
  logic mem_we_raw;
  logic reg_we_raw;

  // R-type function decode: {supported, alu_ctl}.
  function automatic logic [3:0] r_decode(input logic [5:0] f);
    logic [3:0] res;
    case (f)
      6'h20:   res = {1'b1, ALU_ADD};
      6'h22:   res = {1'b1, ALU_SUB};
      6'h24:   res = {1'b1, ALU_AND};
      6'h25:   res = {1'b1, ALU_OR};
      6'h2A:   res = {1'b1, ALU_SLT};
      default: res = {1'b0, ALU_ADD};
    endcase
    return res;
  endfunction

  logic [3:0] r_dec;
  logic       r_ok;
  logic [2:0] r_ctl;

  assign r_dec = r_decode(funct);
  assign r_ok  = r_dec[3];
  assign r_ctl = r_dec[2:0];

  // ori is the only zero-extending immediate instruction.
  logic       i_ext;
  logic [2:0] i_ctl;

  assign i_ext = (op != OP_ORI);
  assign i_ctl = (op == OP_ORI) ? ALU_OR : ALU_ADD;

  // State register and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
      illegal   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state == HALT) begin
        illegal <= 1'b1;
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    nxt_state  = cur_state;
    pc_we_raw  = 1'b0;
    ir_we_raw  = 1'b0;
    mem_re_raw = 1'b0;
    mem_we_raw = 1'b0;
    reg_we_raw = 1'b0;
    ext_op     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_ctl    = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = PC_ALU;

    case (cur_state)
      FETCH: begin
        mem_re_raw = 1'b1;
        alu_src_b  = SRCB_FOUR;
        // IR load and PC increment happen together, only when the read lands.
        if (mem_ready) begin
          ir_we_raw = 1'b1;
          pc_we_raw = 1'b1;
          nxt_state = DECODE;
        end
      end

      DECODE: begin
        // Branch target is computed speculatively and parked in ALUOut.
        alu_src_b = SRCB_IMM4;
        ext_op    = 1'b1;
        case (op)
          OP_LW, OP_SW:     nxt_state = MEM_ADDR;
          OP_RTYPE:         nxt_state = R_EXEC;
          OP_BEQ:           nxt_state = BRANCH;
          OP_J:             nxt_state = JUMP;
          OP_ADDI, OP_ORI:  nxt_state = I_EXEC;
          default:          nxt_state = HALT;
        endcase
      end

      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
        nxt_state = (op == OP_LW) ? MEM_READ : MEM_WRITE;
      end

      MEM_READ: begin
        mem_re_raw = 1'b1;
        if (mem_ready) begin
          nxt_state = MEM_WB;
        end
      end

      MEM_WB: begin
        reg_we_raw = 1'b1;
        mem_to_reg = 1'b1;
        nxt_state  = FETCH;
      end

      MEM_WRITE: begin
        mem_we_raw = 1'b1;
        if (mem_ready) begin
          nxt_state = FETCH;
        end
      end

      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctl   = r_ctl;
        nxt_state = r_ok ? R_WB : HALT;
      end

      R_WB: begin
        // funct is still stable in the IR, so the ALU op is simply re-decoded.
        reg_we_raw = 1'b1;
        reg_dst    = 1'b1;
        alu_ctl    = r_ctl;
        nxt_state  = FETCH;
      end

      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we_raw = zero;
        nxt_state = FETCH;
      end

      JUMP: begin
        pc_src    = PC_JUMP;
        pc_we_raw = 1'b1;
        nxt_state = FETCH;
      end

      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = i_ext;
        alu_ctl   = i_ctl;
        nxt_state = I_WB;
      end

      I_WB: begin
        reg_we_raw = 1'b1;
        ext_op     = i_ext;
        alu_ctl    = i_ctl;
        nxt_state  = FETCH;
      end

      HALT: begin
        nxt_state = HALT;
      end

      default: begin
        // Unreachable encodings are treated like an illegal instruction.
        nxt_state = HALT;
      end
    endcase
  end

  // Reset blocks every side effect in the cycle it is asserted.
  assign pc_we  = pc_we_raw  & ~reset;
  assign ir_we  = ir_we_raw  & ~reset;
  assign mem_re = mem_re_raw & ~reset;
  assign mem_we = mem_we_raw & ~reset;
  assign reg_we = reg_we_raw & ~reset;

  assign state = cur_state;

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control
//
// Self-checking bench for mc_control: a table of per-cycle input/expected
// output rows walked through several instruction sequences, plus latency
// sequences with memory wait states and a per-cycle read/write exclusivity
// check.
// ---------------------------------------------------------------------------
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we, ir_we, mem_re, mem_we, reg_we, ext_op, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctl;
  logic       reg_dst, mem_to_reg;
  logic [1:0] pc_src;
  logic [3:0] state;
  logic       illegal;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .ext_op     (ext_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctl    (alu_ctl),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .state      (state),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic       ext_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mr;
    outs_t      exp;
  } vec_t;

  outs_t act;
  assign act = {pc_we, ir_we, mem_re, mem_we, reg_we, ext_op, alu_src_a,
                alu_src_b, alu_ctl, reg_dst, mem_to_reg, pc_src, state, illegal};

  vec_t  tbl[$];
  outs_t sb[$];

  function automatic outs_t E(int st, bit pcw, bit irw, bit mre, bit mwe, bit rwe,
                              bit ext, bit asa, int asb, int ctl, bit rd, bit m2r,
                              int psrc, bit ill);
    outs_t o;
    o.pc_we = pcw;  o.ir_we = irw;  o.mem_re = mre;  o.mem_we = mwe;
    o.reg_we = rwe; o.ext_op = ext; o.alu_src_a = asa;
    o.alu_src_b = asb[1:0]; o.alu_ctl = ctl[2:0];
    o.reg_dst = rd; o.mem_to_reg = m2r; o.pc_src = psrc[1:0];
    o.state = st[3:0]; o.illegal = ill;
    return o;
  endfunction

  task automatic add(input string n, input bit r, input logic [5:0] o,
                     input logic [5:0] f, input bit z, input bit m, input outs_t e);
    vec_t v;
    v.name = n; v.rst = r; v.op = o; v.funct = f; v.zero = z; v.mr = m; v.exp = e;
    tbl.push_back(v);
  endtask

  // Read and write requests must never overlap.
  always begin
    @(negedge clk);
    #3;
    if (mon_en) begin
      checks++;
      if (mem_re === 1'b1 && mem_we === 1'b1) begin
        failures++;
        $display("FAIL rw_excl: mem_re=%b mem_we=%b required not both 1", mem_re, mem_we);
      end
    end
  end

  // Runs one instruction from reset and counts cycles until FETCH returns.
  task automatic lat(input string n, input logic [5:0] o, input bit z,
                     input int waits, input int exp_cycles);
    int cnt  = 0;
    int w    = waits;
    bit left = 1'b0;
    bit done = 1'b0;
    @(negedge clk);
    reset = 1'b1; op = o; funct = 6'h20; zero = z; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      #2;
      if (state == 4'd0 && left) begin
        done = 1'b1;
      end else begin
        if (state != 4'd0) left = 1'b1;
        cnt++;
        if ((state == 4'd3 || state == 4'd5) && w > 0) begin
          mem_ready = 1'b0;
          w--;
        end else begin
          mem_ready = 1'b1;
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: timeout, FETCH not reached within 50 cycles", n);
    end else if (cnt != exp_cycles) begin
      failures++;
      $display("FAIL %s: cycles=%0d required=%0d", n, cnt, exp_cycles);
    end
  endtask

  initial begin
    outs_t fok, fwait, dec, ma, mrd, mwb, mw, hlt;
    fok   = E(0, 1,1,1,0,0, 0,0,1,0, 0,0,0, 0);
    fwait = E(0, 0,0,1,0,0, 0,0,1,0, 0,0,0, 0);
    dec   = E(1, 0,0,0,0,0, 1,0,3,0, 0,0,0, 0);
    ma    = E(2, 0,0,0,0,0, 1,1,2,0, 0,0,0, 0);
    mrd   = E(3, 0,0,1,0,0, 0,0,0,0, 0,0,0, 0);
    mwb   = E(4, 0,0,0,0,1, 0,0,0,0, 0,1,0, 0);
    mw    = E(5, 0,0,0,1,0, 0,0,0,0, 0,0,0, 0);
    hlt   = E(12,0,0,0,0,0, 0,0,0,0, 0,0,0, 1);

    // lw, no waits
    add("lw_fetch", 0, 6'h23, 6'h00, 0, 1, fok);
    add("lw_dec",   0, 6'h23, 6'h00, 0, 1, dec);
    add("lw_addr",  0, 6'h23, 6'h00, 0, 1, ma);
    add("lw_read",  0, 6'h23, 6'h00, 0, 1, mrd);
    add("lw_wb",    0, 6'h23, 6'h00, 0, 1, mwb);
    // ori with one fetch wait
    add("ori_fwait", 0, 6'h0D, 6'h01, 0, 0, fwait);
    add("ori_fetch", 0, 6'h0D, 6'h01, 0, 1, fok);
    add("ori_dec",   0, 6'h0D, 6'h01, 0, 1, dec);
    add("ori_exec",  0, 6'h0D, 6'h01, 0, 1, E(10,0,0,0,0,0, 0,1,2,3, 0,0,0, 0));
    add("ori_wb",    0, 6'h0D, 6'h01, 0, 1, E(11,0,0,0,0,1, 0,0,0,3, 0,0,0, 0));
    // addi
    add("addi_fetch", 0, 6'h08, 6'h00, 0, 1, fok);
    add("addi_dec",   0, 6'h08, 6'h00, 0, 1, dec);
    add("addi_exec",  0, 6'h08, 6'h00, 0, 1, E(10,0,0,0,0,0, 1,1,2,0, 0,0,0, 0));
    add("addi_wb",    0, 6'h08, 6'h00, 0, 1, E(11,0,0,0,0,1, 1,0,0,0, 0,0,0, 0));
    // R-type sub, slt, and
    add("sub_fetch", 0, 6'h00, 6'h22, 0, 1, fok);
    add("sub_dec",   0, 6'h00, 6'h22, 0, 1, dec);
    add("sub_exec",  0, 6'h00, 6'h22, 0, 1, E(6,0,0,0,0,0, 0,1,0,1, 0,0,0, 0));
    add("sub_wb",    0, 6'h00, 6'h22, 0, 1, E(7,0,0,0,0,1, 0,0,0,1, 1,0,0, 0));
    add("slt_fetch", 0, 6'h00, 6'h2A, 0, 1, fok);
    add("slt_dec",   0, 6'h00, 6'h2A, 0, 1, dec);
    add("slt_exec",  0, 6'h00, 6'h2A, 0, 1, E(6,0,0,0,0,0, 0,1,0,4, 0,0,0, 0));
    add("slt_wb",    0, 6'h00, 6'h2A, 0, 1, E(7,0,0,0,0,1, 0,0,0,4, 1,0,0, 0));
    add("and_fetch", 0, 6'h00, 6'h24, 0, 1, fok);
    add("and_dec",   0, 6'h00, 6'h24, 0, 1, dec);
    add("and_exec",  0, 6'h00, 6'h24, 0, 1, E(6,0,0,0,0,0, 0,1,0,2, 0,0,0, 0));
    add("and_wb",    0, 6'h00, 6'h24, 0, 1, E(7,0,0,0,0,1, 0,0,0,2, 1,0,0, 0));
    // beq taken / not taken
    add("beqt_fetch", 0, 6'h04, 6'h00, 1, 1, fok);
    add("beqt_dec",   0, 6'h04, 6'h00, 1, 1, dec);
    add("beqt_br",    0, 6'h04, 6'h00, 1, 1, E(8,1,0,0,0,0, 0,1,0,1, 0,0,1, 0));
    add("beqn_fetch", 0, 6'h04, 6'h00, 0, 1, fok);
    add("beqn_dec",   0, 6'h04, 6'h00, 0, 1, dec);
    add("beqn_br",    0, 6'h04, 6'h00, 0, 1, E(8,0,0,0,0,0, 0,1,0,1, 0,0,1, 0));
    // j
    add("j_fetch", 0, 6'h02, 6'h00, 0, 1, fok);
    add("j_dec",   0, 6'h02, 6'h00, 0, 1, dec);
    add("j_jump",  0, 6'h02, 6'h00, 0, 1, E(9,1,0,0,0,0, 0,0,0,0, 0,0,2, 0));
    // sw with three write waits
    add("sw_fetch", 0, 6'h2B, 6'h00, 0, 1, fok);
    add("sw_dec",   0, 6'h2B, 6'h00, 0, 1, dec);
    add("sw_addr",  0, 6'h2B, 6'h00, 0, 1, ma);
    add("sw_w0",    0, 6'h2B, 6'h00, 0, 0, mw);
    add("sw_w1",    0, 6'h2B, 6'h00, 0, 0, mw);
    add("sw_w2",    0, 6'h2B, 6'h00, 0, 0, mw);
    add("sw_w3",    0, 6'h2B, 6'h00, 0, 1, mw);
    // lw aborted by reset during a read wait
    add("lwa_fetch", 0, 6'h23, 6'h00, 0, 1, fok);
    add("lwa_dec",   0, 6'h23, 6'h00, 0, 1, dec);
    add("lwa_addr",  0, 6'h23, 6'h00, 0, 1, ma);
    add("lwa_rd0",   0, 6'h23, 6'h00, 0, 0, mrd);
    add("lwa_rd1",   0, 6'h23, 6'h00, 0, 0, mrd);
    add("lwa_rst",   1, 6'h23, 6'h00, 0, 0, E(3,0,0,0,0,0, 0,0,0,0, 0,0,0, 0));
    // illegal opcode then reset
    add("ill_fetch", 0, 6'h3F, 6'h00, 0, 1, fok);
    add("ill_dec",   0, 6'h3F, 6'h00, 0, 1, dec);
    add("ill_halt0", 0, 6'h3F, 6'h00, 1, 1, hlt);
    add("ill_halt1", 0, 6'h3F, 6'h00, 1, 1, hlt);
    add("ill_rst",   1, 6'h3F, 6'h00, 1, 1, hlt);
    // R-type with unsupported funct, then reset, then reset during FETCH
    add("rbad_fetch", 0, 6'h00, 6'h00, 0, 1, fok);
    add("rbad_dec",   0, 6'h00, 6'h00, 0, 1, dec);
    add("rbad_exec",  0, 6'h00, 6'h00, 0, 1, E(6,0,0,0,0,0, 0,1,0,0, 0,0,0, 0));
    add("rbad_halt",  0, 6'h00, 6'h00, 0, 1, hlt);
    add("rbad_rst",   1, 6'h00, 6'h00, 0, 1, hlt);
    add("rst_fetch",  1, 6'h00, 6'h00, 0, 1, E(0,0,0,0,0,0, 0,0,1,0, 0,0,0, 0));
    add("post_fetch", 0, 6'h00, 6'h20, 0, 1, fok);

    reset = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; op = tbl[i].op; funct = tbl[i].funct;
      zero = tbl[i].zero; mem_ready = tbl[i].mr;
      sb.push_back(tbl[i].exp);
      #2;
      begin
        outs_t e;
        e = sb.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s (row %0d): outputs=%h required=%h state=%0d", tbl[i].name, i,
                   act, e, state);
        end
      end
    end

    lat("lat_lw0",  6'h23, 1'b0, 0, 5);
    lat("lat_lw2",  6'h23, 1'b0, 2, 7);
    lat("lat_sw3",  6'h2B, 1'b0, 3, 7);
    lat("lat_ori",  6'h0D, 1'b0, 0, 4);
    lat("lat_beq",  6'h04, 1'b1, 0, 3);
    lat("lat_j",    6'h02, 1'b0, 0, 3);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
